// File: rtl/inv_clarke_pwm_sched.sv
// -----------------------------------------------------------------------------
// inv_clarke_pwm_sched
//
// Accepts one (alpha, beta) voltage command per handshake, runs the inverse
// Clarke transform over a few cycles on a registered multiply/sum datapath,
// saturates the phase values, converts them to offset-binary duties and hands
// them to an edge-aligned PWM generator through a shadow/active double buffer.
// New duties only become active on a PWM period boundary (counter wrap).
//
// Parameters:
//   WIDTH           signed width of alpha/beta/phases; PWM counter and duty
//                   width (period = 2^WIDTH clocks)
//   FRACTIONAL_BITS fractional bits of K = floor(sqrt(3)/2 * 2^FRACTIONAL_BITS)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   en                        PWM enable (0 holds counter at 0, pwm low)
//   in_valid / in_ready       command handshake (ready only in IDLE)
//   alpha, beta               signed voltage command
//   pwm_a, pwm_b, pwm_c       registered PWM outputs
//   duty_a, duty_b, duty_c    currently active duties (offset binary)
//   period_start              pulse in the cycle after the counter wraps
//   update_done               pulse in the cycle after shadow -> active commit
// -----------------------------------------------------------------------------
module inv_clarke_pwm_sched #(
  parameter int WIDTH           = 10,
  parameter int FRACTIONAL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] alpha,
  input  logic signed [WIDTH-1:0] beta,
  output logic                    pwm_a,
  output logic                    pwm_b,
  output logic                    pwm_c,
  output logic [WIDTH-1:0]        duty_a,
  output logic [WIDTH-1:0]        duty_b,
  output logic [WIDTH-1:0]        duty_c,
  output logic                    period_start,
  output logic                    update_done
);

  localparam int PW = WIDTH + FRACTIONAL_BITS + 1;
  localparam int SW = WIDTH + 2;

  // Integer square root by bitwise binary search; used only at elaboration.
  function automatic longint isqrt(input longint x);
    longint r;
    longint trial;
    r = 0;
    for (int i = 31; i >= 0; i--) begin
      trial = r | (longint'(1) << i);
      if (trial * trial <= x) r = trial;
    end
    return r;
  endfunction

  // floor(sqrt(3)/2 * 2^F) == floor(isqrt(3 * 4^F) / 2)
  localparam longint K_L = isqrt(longint'(3) << (2 * FRACTIONAL_BITS)) >> 1;
  localparam logic signed [FRACTIONAL_BITS:0] K = (FRACTIONAL_BITS + 1)'(K_L);

  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] TOP = {WIDTH{1'b1}};

  // Clamp a wide signed value to the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] x);
    if (x[SW-1:WIDTH-1] == '0 || x[SW-1:WIDTH-1] == '1)
      return x[WIDTH-1:0];
    else if (x[SW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Adding 2^(WIDTH-1) to a two's-complement value is an MSB flip.
  function automatic logic [WIDTH-1:0] to_duty(input logic signed [WIDTH-1:0] p);
    return {~p[WIDTH-1], p[WIDTH-2:0]};
  endfunction

  typedef enum logic [2:0] {IDLE, MUL, SUM, LOAD, WAIT} state_t;
  state_t state;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow_a, shadow_b, shadow_c;
  logic             wrap;

  logic signed [WIDTH-1:0] alpha_p0, beta_p0;
  logic signed [PW-1:0]    prod_p1;
  logic signed [WIDTH-1:0] phase_a_p2, phase_b_p2, phase_c_p2;
  logic signed [SW-1:0]    t_sum, half_sum, b_sum, c_sum;

  assign wrap = en && (cnt == TOP);

  always_comb begin
    t_sum    = SW'(prod_p1 >>> FRACTIONAL_BITS);
    half_sum = SW'(alpha_p0) >>> 1;
    b_sum    = t_sum - half_sum;
    c_sum    = -t_sum - half_sum;
  end

  always_ff @(posedge clk) begin
    // p0: command capture on handshake
    if (in_valid && in_ready) begin
      alpha_p0 <= alpha;
      beta_p0  <= beta;
    end
    // p1: beta * K
    if (state == MUL)
      prod_p1 <= PW'(beta_p0) * PW'(K);
    // p2: saturated phase values
    if (state == SUM) begin
      phase_a_p2 <= alpha_p0;
      phase_b_p2 <= sat(b_sum);
      phase_c_p2 <= sat(c_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      cnt          <= '0;
      shadow_a     <= MID;
      shadow_b     <= MID;
      shadow_c     <= MID;
      duty_a       <= MID;
      duty_b       <= MID;
      duty_c       <= MID;
      pwm_a        <= 1'b0;
      pwm_b        <= 1'b0;
      pwm_c        <= 1'b0;
      period_start <= 1'b0;
      update_done  <= 1'b0;
    end else begin
      cnt          <= en ? cnt + WIDTH'(1) : '0;
      // compared against the active duties, so a commit on the wrap edge
      // shows up starting with the cnt = 0 cycle
      pwm_a        <= en && (cnt < duty_a);
      pwm_b        <= en && (cnt < duty_b);
      pwm_c        <= en && (cnt < duty_c);
      period_start <= wrap;
      update_done  <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL:  state <= SUM;
        SUM:  state <= LOAD;
        LOAD: begin
          shadow_a <= to_duty(phase_a_p2);
          shadow_b <= to_duty(phase_b_p2);
          shadow_c <= to_duty(phase_c_p2);
          state    <= WAIT;
        end
        WAIT: begin
          if (wrap) begin
            duty_a      <= shadow_a;
            duty_b      <= shadow_b;
            duty_c      <= shadow_c;
            update_done <= 1'b1;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
